// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream loader that fills instruction memory and releases core reset.
// Define CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LEN_LO | expecting low byte of word count
// LEN_HI | expecting high byte of word count
// DATA   | assembling and writing payload words
// CHK    | expecting checksum byte (CHECKSUM_EN only)
// DONE   | image loaded, core released
// ERR    | load aborted, core held in reset
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 128,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             core_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_loaded
);

`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
`endif

  state_t           state;
  logic [7:0]       len_lo;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] index;
  logic [1:0]       lane;
  logic [23:0]      word;
  logic [15:0]      len_full;
  logic             accept;
`ifdef CHECKSUM_EN
  logic [7:0]       csum;
`endif

`ifdef CHECKSUM_EN
  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) ||
                        (state == DATA) || (state == CHK);
`else
  assign bus.in_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
`endif

  assign accept   = bus.in_valid && bus.in_ready;
  assign len_full = {bus.in_data, len_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_lo       <= '0;
      last_idx     <= '0;
      index        <= '0;
      lane         <= '0;
      word         <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= BASE_ADDR;
      bus.wr_data  <= '0;
      core_reset   <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b1;
            core_reset   <= 1'b1;
            words_loaded <= '0;
            lane         <= '0;
            index        <= '0;
`ifdef CHECKSUM_EN
            csum         <= '0;
`endif
          end
        end
        LEN_LO: begin
          if (accept) begin
            len_lo <= bus.in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            if (len_full == 16'd0 || len_full > 16'(MAX_WORDS)) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              last_idx <= CNT_W'(len_full - 16'd1);
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            lane <= lane + 2'd1;
`ifdef CHECKSUM_EN
            csum <= csum ^ bus.in_data;
`endif
            case (lane)
              2'd0: word[7:0]   <= bus.in_data;
              2'd1: word[15:8]  <= bus.in_data;
              2'd2: word[23:16] <= bus.in_data;
              default: begin
                // Write is registered here so it appears the cycle after the 4th byte.
                bus.wr_en    <= 1'b1;
                bus.wr_addr  <= BASE_ADDR + (32'(index) << 2);
                bus.wr_data  <= {bus.in_data, word};
                index        <= index + 1'b1;
                words_loaded <= words_loaded + 1'b1;
                if (index == last_idx) begin
`ifdef CHECKSUM_EN
                  state <= CHK;
`else
                  state      <= DONE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  core_reset <= 1'b0;
`endif
                end
              end
            endcase
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (accept) begin
            busy <= 1'b0;
            if (bus.in_data == csum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
